// File: rtl/ccn_send_arbiter_pkg.sv
// Shared CCN constants, send-FSM state encoding and the send word payload.
// Imported by the send arbiter and its round-robin picker.
package ccn_send_arbiter_pkg;

  localparam int unsigned CCN_NUM_FPUS = 16;
  localparam int unsigned CCN_FPU_ID_W = 4;
  localparam int unsigned CCN_CHAN_W   = 8;
  localparam int unsigned CCN_MSG_W    = 32;
  localparam int unsigned CCN_CNT_W    = 16;

  typedef enum logic {
    CCN_ST_IDLE = 1'b0,
    CCN_ST_BUSY = 1'b1
  } ccn_send_state_e;

  typedef struct packed {
    logic [CCN_CHAN_W-1:0] channel_id;
    logic [CCN_MSG_W-1:0]  message;
  } ccn_word_t;

  // Saturating increment for the debug counters.
  function automatic logic [CCN_CNT_W-1:0] ccn_sat_inc(input logic [CCN_CNT_W-1:0] v);
    return (&v) ? v : v + CCN_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ccn_rr_picker.sv
// Round-robin priority search: first eligible index strictly after last_grant,
// wrapping modulo NUM_FPUS. Purely combinational.
module ccn_rr_picker
  import ccn_send_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FPUS = CCN_NUM_FPUS
) (
  input  logic [NUM_FPUS-1:0]     eligible,
  input  logic [CCN_FPU_ID_W-1:0] last_grant,
  output logic                    any,
  output logic [CCN_FPU_ID_W-1:0] winner
);

  logic [CCN_FPU_ID_W-1:0] idx;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_FPUS; k++) begin
      idx = CCN_FPU_ID_W'((32'(last_grant) + k) % NUM_FPUS);
      if (!any && eligible[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ccn_send_arbiter.sv
// Arbitrates NUM_FPUS send requesters round-robin onto the single CCN send port,
// holding one registered word and sustaining one word per cycle when ready.
module ccn_send_arbiter
  import ccn_send_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FPUS = CCN_NUM_FPUS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FPUS-1:0]            fpu_enable,
  input  logic [NUM_FPUS-1:0]            req_valid,
  input  logic [NUM_FPUS*CCN_CHAN_W-1:0] req_channel_id,
  input  logic [NUM_FPUS*CCN_MSG_W-1:0]  req_message,
  output logic [NUM_FPUS-1:0]            req_ready,
  output logic [CCN_CHAN_W-1:0]          ccn_channel_id,
  output logic [CCN_MSG_W-1:0]           ccn_message,
  output logic                           ccn_send_valid,
  input  logic                           ccn_send_ready,
  output logic [CCN_FPU_ID_W-1:0]        grant_fpu_id,
  output logic [CCN_CNT_W-1:0]           debug_grant_count,
  output logic [CCN_CNT_W-1:0]           debug_stall_count
);

  localparam int unsigned IDW = CCN_FPU_ID_W;

  ccn_send_state_e      state_q, state_d;
  ccn_word_t            word_q, word_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [CCN_CNT_W-1:0] gcnt_q, gcnt_d;
  logic [CCN_CNT_W-1:0] scnt_q, scnt_d;

  logic [NUM_FPUS-1:0]  eligible_c;
  logic                 any_c;
  logic [IDW-1:0]       winner_c;
  logic                 window_c;
  logic                 accept_c;
  ccn_word_t            winner_word_c;

  assign eligible_c = req_valid & fpu_enable;

  ccn_rr_picker #(
    .NUM_FPUS (NUM_FPUS)
  ) u_picker (
    .eligible   (eligible_c),
    .last_grant (last_q),
    .any        (any_c),
    .winner     (winner_c)
  );

  // A new word can be taken when nothing is held or the held word leaves this cycle.
  assign window_c  = (state_q == CCN_ST_IDLE) || ccn_send_ready;
  assign accept_c  = window_c && any_c;
  assign req_ready = (accept_c && !reset) ? (NUM_FPUS'(1) << winner_c) : '0;

  always_comb begin
    winner_word_c.channel_id = req_channel_id[32'(winner_c)*CCN_CHAN_W +: CCN_CHAN_W];
    winner_word_c.message    = req_message[32'(winner_c)*CCN_MSG_W +: CCN_MSG_W];
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    grant_d = grant_q;
    last_d  = last_q;
    gcnt_d  = gcnt_q;
    scnt_d  = scnt_q;
    if (accept_c) begin
      state_d = CCN_ST_BUSY;
      word_d  = winner_word_c;
      grant_d = winner_c;
      last_d  = winner_c;
      gcnt_d  = ccn_sat_inc(gcnt_q);
    end else if ((state_q == CCN_ST_BUSY) && ccn_send_ready) begin
      state_d = CCN_ST_IDLE;
    end
    if ((state_q == CCN_ST_BUSY) && !ccn_send_ready) begin
      scnt_d = ccn_sat_inc(scnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CCN_ST_IDLE;
      word_q  <= '0;
      grant_q <= '0;
      last_q  <= IDW'(NUM_FPUS - 1);
      gcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      gcnt_q  <= gcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign ccn_send_valid    = (state_q == CCN_ST_BUSY);
  assign ccn_channel_id    = word_q.channel_id;
  assign ccn_message       = word_q.message;
  assign grant_fpu_id      = grant_q;
  assign debug_grant_count = gcnt_q;
  assign debug_stall_count = scnt_q;

endmodule

// File: tb/tb_ccn_send_arbiter.sv
// Scoreboard bench for ccn_send_arbiter: directed scenarios plus random traffic
// checked against a behavioural round-robin model.
module tb_ccn_send_arbiter;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [15:0]   fpu_enable = '0;
  logic [15:0]   req_valid = '0;
  logic [127:0]  req_channel_id = '0;
  logic [511:0]  req_message = '0;
  logic [15:0]   req_ready;
  logic [7:0]    ccn_channel_id;
  logic [31:0]   ccn_message;
  logic          ccn_send_valid;
  logic          ccn_send_ready = 1'b0;
  logic [3:0]    grant_fpu_id;
  logic [15:0]   debug_grant_count;
  logic [15:0]   debug_stall_count;

  ccn_send_arbiter #(.NUM_FPUS(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .fpu_enable        (fpu_enable),
    .req_valid         (req_valid),
    .req_channel_id    (req_channel_id),
    .req_message       (req_message),
    .req_ready         (req_ready),
    .ccn_channel_id    (ccn_channel_id),
    .ccn_message       (ccn_message),
    .ccn_send_valid    (ccn_send_valid),
    .ccn_send_ready    (ccn_send_ready),
    .grant_fpu_id      (grant_fpu_id),
    .debug_grant_count (debug_grant_count),
    .debug_stall_count (debug_stall_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [7:0]  ch;
    logic [31:0] msg;
  } word_t;

  word_t      exp_q[$];
  logic [3:0] log_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         hold_data = 1'b0;

  // Reference model state
  bit m_busy = 1'b0;
  int m_last = 15;
  int m_gcnt = 0;
  int m_scnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [15:0] e, input int last);
    for (int k = 1; k <= 16; k++) begin
      int idx;
      idx = (last + k) % 16;
      if (e[idx]) return idx;
    end
    return -1;
  endfunction

  // One clock of stimulus; the model predicts req_ready and queues accepted words.
  task automatic drive_cycle(input logic [15:0] v, input logic [15:0] en, input logic rdy);
    int          w;
    bit          window;
    logic [15:0] exp_rdy;
    word_t       wd;
    @(negedge clk);
    req_valid      = v;
    fpu_enable     = en;
    ccn_send_ready = rdy;
    if (!hold_data) begin
      for (int i = 0; i < 16; i++) begin
        req_channel_id[i*8 +: 8]  = 8'($urandom);
        req_message[i*32 +: 32]   = $urandom;
      end
    end
    #1;
    chk("valid", 64'(ccn_send_valid), 64'(m_busy));
    chk("grant_count", 64'(debug_grant_count), 64'(m_gcnt));
    chk("stall_count", 64'(debug_stall_count), 64'(m_scnt));
    window  = !m_busy || rdy;
    w       = pick(v & en, m_last);
    exp_rdy = (window && w >= 0) ? (16'(1) << w) : 16'h0;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (m_busy && !rdy && m_scnt < 65535) m_scnt++;
    if (window && w >= 0) begin
      wd.id  = 4'(w);
      wd.ch  = req_channel_id[w*8 +: 8];
      wd.msg = req_message[w*32 +: 32];
      exp_q.push_back(wd);
      m_last = w;
      m_busy = 1'b1;
      if (m_gcnt < 65535) m_gcnt++;
    end else if (m_busy && rdy) begin
      m_busy = 1'b0;
    end
  endtask

  // Asserts reset mid-cycle; anything held is dropped from the expectations.
  task automatic reset_dut();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_valid", 64'(ccn_send_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_word", 64'({grant_fpu_id, ccn_channel_id, ccn_message}), 64'(0));
    chk("rst_counts", 64'({debug_grant_count, debug_stall_count}), 64'(0));
    exp_q.delete();
    log_q.delete();
    m_busy = 1'b0;
    m_last = 15;
    m_gcnt = 0;
    m_scnt = 0;
    req_valid      = '0;
    ccn_send_ready = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: every presented word must match the oldest accepted word.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (ccn_send_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual_id=%0d required=none t=%0t", grant_fpu_id, $time);
        end else begin
          chk("word", 64'({grant_fpu_id, ccn_channel_id, ccn_message}), 64'(exp_q[0]));
          if (ccn_send_ready) begin
            log_q.push_back(grant_fpu_id);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // FPU3 single send
    reset_dut();
    hold_data = 1'b1;
    req_channel_id = '0;
    req_message    = '0;
    req_channel_id[31:24] = 8'h12;
    req_message[127:96]   = 32'hDEADBEEF;
    drive_cycle(16'h0008, 16'hFFFF, 1'b1);
    chk("s1_req_ready", 64'(req_ready), 64'(16'h0008));
    drive_cycle(16'h0000, 16'hFFFF, 1'b1);
    chk("s1_valid", 64'(ccn_send_valid), 64'(1));
    chk("s1_channel", 64'(ccn_channel_id), 64'(8'h12));
    chk("s1_message", 64'(ccn_message), 64'(32'hDEADBEEF));
    chk("s1_grant", 64'(grant_fpu_id), 64'(3));
    hold_data = 1'b0;

    // All 16 requesting for 17 cycles
    reset_dut();
    repeat (17) drive_cycle(16'hFFFF, 16'hFFFF, 1'b1);
    drive_cycle(16'h0000, 16'hFFFF, 1'b1);
    chk("s2_grant_count", 64'(debug_grant_count), 64'(17));
    #3;
    chk("s2_log_size", 64'(log_q.size()), 64'(17));
    for (int i = 0; i < 17 && i < log_q.size(); i++)
      chk("s2_order", 64'(log_q[i]), 64'(i % 16));

    // Backpressure for 5 cycles
    reset_dut();
    drive_cycle(16'h0003, 16'hFFFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(16'h0003, 16'hFFFF, 1'b0);
      chk("s3_stall_ready", 64'(req_ready), 64'(0));
    end
    drive_cycle(16'h0003, 16'hFFFF, 1'b1);
    chk("s3_reload_ready", 64'(req_ready), 64'(16'h0002));
    drive_cycle(16'h0000, 16'hFFFF, 1'b1);
    chk("s3_stall_count", 64'(debug_stall_count), 64'(5));

    // FPU2 masked
    reset_dut();
    drive_cycle(16'h0001, 16'hFFFF, 1'b1);
    drive_cycle(16'h000E, 16'hFFFB, 1'b1);
    drive_cycle(16'h000E, 16'hFFFB, 1'b1);
    drive_cycle(16'h0000, 16'hFFFF, 1'b1);
    #3;
    chk("s4_log_size", 64'(log_q.size()), 64'(3));
    chk("s4_order", 64'({log_q[0], log_q[1], log_q[2]}), 64'(12'h013));

    // Reset while BUSY, then FPU0 wins over FPU5
    reset_dut();
    drive_cycle(16'h0001, 16'hFFFF, 1'b1);
    reset_dut();
    drive_cycle(16'h0021, 16'hFFFF, 1'b1);
    chk("s5_req_ready", 64'(req_ready), 64'(16'h0001));
    drive_cycle(16'h0000, 16'hFFFF, 1'b1);
    #3;
    chk("s5_log_size", 64'(log_q.size()), 64'(1));
    chk("s5_first", 64'(log_q[0]), 64'(0));

    // Random traffic
    reset_dut();
    repeat (400)
      drive_cycle(16'($urandom), 16'($urandom | $urandom), ($urandom % 4) != 0);
    drive_cycle(16'h0000, 16'hFFFF, 1'b1);
    drive_cycle(16'h0000, 16'hFFFF, 1'b1);
    #3;
    chk("rand_drained", 64'(exp_q.size()), 64'(0));

    // Grant counter saturation
    reset_dut();
    repeat (65540) drive_cycle(16'hFFFF, 16'hFFFF, 1'b1);
    drive_cycle(16'h0000, 16'hFFFF, 1'b1);
    chk("sat_grant_count", 64'(debug_grant_count), 64'(16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccn_send_arbiter.md
CCN_SEND_ARBITER -- requirements
Module: ccn_send_arbiter

Interface
REQ-001 SHALL have parameter NUM_FPUS, default 16, meaning the number of requesting FPUs (index width 4 bits).
REQ-002 SHALL have ports, one per line:
- clk  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-high reset.
- fpu_enable  in  NUM_FPUS  per-FPU arbitration enable mask.
- req_valid  in  NUM_FPUS  per-FPU send request.
- req_channel_id  in  NUM_FPUS*8  packed channel IDs; FPU i at bits [8i+7:8i].
- req_message  in  NUM_FPUS*32  packed messages; FPU i at bits [32i+31:32i].
- req_ready  out  NUM_FPUS  one-hot accept to the winning FPU.
- ccn_channel_id  out  8  channel ID toward the CCN send port.
- ccn_message  out  32  message toward the CCN send port.
- ccn_send_valid  out  1  CCN send request.
- ccn_send_ready  in  1  CCN accepts the send.
- grant_fpu_id  out  4  source FPU of the current ccn_* word.
- debug_grant_count  out  16  count of accepted requests.
- debug_stall_count  out  16  count of cycles with valid high and ready low.

Function
REQ-003 SHALL implement a two-state FSM: IDLE (no word held) and BUSY (word held; ccn_send_valid=1).
REQ-004 SHALL define eligible[i] = req_valid[i] & fpu_enable[i].
REQ-005 SHALL choose the winner round-robin: search from last_grant+1 upward modulo NUM_FPUS, and select the first eligible index.
REQ-006 SHALL define the accept window as: state==IDLE, or (state==BUSY and ccn_send_ready==1).
REQ-007 SHALL drive req_ready combinationally:
- one-hot on the winner when the accept window is open and any eligible bit is set;
- all zero otherwise.
- req_ready SHALL NOT depend on req_valid of non-eligible FPUs.
REQ-008 SHALL perform these actions on an accept (the winner has req_valid & req_ready):
- register that FPU's channel ID and message into ccn_channel_id / ccn_message;
- set grant_fpu_id to the winner;
- set last_grant to the winner;
- set state BUSY.
REQ-009 SHALL have latency of exactly 1 cycle from the accept edge to ccn_send_valid=1 with the accepted data.
REQ-010 SHALL hold ccn_channel_id, ccn_message and grant_fpu_id stable while ccn_send_valid=1 and ccn_send_ready=0.
REQ-011 SHALL handle BUSY with ccn_send_ready=1 as follows:
- if an accept occurs in the same cycle, load the new word and remain BUSY, sustaining 1 word/cycle;
- otherwise go IDLE.
REQ-012 SHALL increment debug_grant_count on each accept, saturating at 16'hFFFF.
REQ-013 SHALL increment debug_stall_count each cycle with ccn_send_valid=1 and ccn_send_ready=0, saturating at 16'hFFFF.
REQ-014 SHALL use an fpu_enable change only for future arbitration; it SHALL NOT affect a word already held.
REQ-015 SHALL treat no eligible requester as: no accept, and last_grant unchanged.

Reset
REQ-016 SHALL, on reset assertion, asynchronously force:
- state=IDLE;
- ccn_send_valid=0;
- ccn_channel_id=8'h00, ccn_message=32'h0;
- grant_fpu_id=4'h0, last_grant=NUM_FPUS-1 (FPU 0 has first priority);
- both debug counters=0.
REQ-017 SHALL hold req_ready all zero while reset is asserted.
REQ-018 SHALL discard a word held when reset asserts mid-transfer; it SHALL NOT be replayed.

Structure
REQ-019 SHALL take the FPU-count, channel-ID width (8) and message width (32) constants from the shared CCN package.
REQ-020 SHALL define the FSM state encoding in the shared CCN package.
REQ-021 SHALL place the round-robin priority search in one combinational sub-module, ccn_rr_picker, taking (eligible, last_grant) and returning (any, winner).

Verification
REQ-022 SHALL cover these directed scenarios:
- FPU3 requests ch 0x12, msg 0xDEADBEEF, ready=1 -> req_ready=16'h0008 that cycle; next cycle ccn_send_valid=1, ccn_channel_id=0x12, ccn_message=0xDEADBEEF, grant_fpu_id=3.
- All 16 FPUs valid and enabled, ready held 1, 17 cycles -> grant order 0,1,...,15,0 with one word per cycle; debug_grant_count=17.
- Word held, ccn_send_ready low 5 cycles -> ccn_* outputs stable, req_ready=0, debug_stall_count=5; on ready high the next winner loads the same cycle.
- fpu_enable=16'hFFFB, FPUs 1, 2, 3 requesting, last_grant=0 -> grants 1 then 3; FPU2 is never granted.
- Reset asserted mid-cycle while BUSY -> ccn_send_valid=0 immediately (asynchronously); after release, with FPUs 0 and 5 requesting, the first grant is FPU0.
- Forced debug_grant_count=16'hFFFE, then 3 accepts -> counter reads 16'hFFFF.
